// File: rtl/mesochronous_sync_arbiter.sv
// mesochronous_sync_arbiter
//   Shares the write side of one mesochronous synchronizer between REQUESTERS
//   sources in the wrclk_i domain. One requester is granted per cycle using
//   round-robin priority with optional bounded burst locking. Every cycle a
//   tagged word {valid,id,data} (or an all-zero idle word) is registered for
//   the synchronizer d_i input. After reset, no grants are issued for
//   STARTUP_CYCLES cycles so the read-side pointer can align first.
//
// Ports
//   wrrst_ni  : asynchronous active-low reset
//   wrclk_i   : write-domain clock
//   req_i     : per-requester request (level)
//   lock_i    : per-requester burst lock, only meaningful with req_i
//   data_i    : payloads, requester k at [k*DATA_SIZE +: DATA_SIZE]
//   gnt_o     : one-hot/zero grant; data_i[k] is consumed at this edge
//   ready_o   : startup window finished
//   sync_d_o  : registered {valid,id,data} word for the synchronizer
module mesochronous_sync_arbiter #(
  parameter int unsigned REQUESTERS     = 4,
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned STARTUP_CYCLES = 4,
  parameter int unsigned MAX_BURST      = 8,
  localparam int unsigned ID_W   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1,
  localparam int unsigned SYNC_W = 1 + ID_W + DATA_SIZE
) (
  input  logic                            wrrst_ni,
  input  logic                            wrclk_i,
  input  logic [REQUESTERS-1:0]           req_i,
  input  logic [REQUESTERS-1:0]           lock_i,
  input  logic [REQUESTERS*DATA_SIZE-1:0] data_i,
  output logic [REQUESTERS-1:0]           gnt_o,
  output logic                            ready_o,
  output logic [SYNC_W-1:0]               sync_d_o
);

  localparam int unsigned CNT_W   = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_STARTUP,
    ST_ARB
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [SYNC_W-1:0]    sync_d_q, sync_d_d;

  logic                 gnt_valid;
  logic [ID_W-1:0]      gnt_idx;
  logic                 lock_hit;
  logic                 burst_room;
  int unsigned          cand;

  // Startup sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
          state_d = ST_ARB;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ARB: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_STARTUP;
      end
    endcase
  end

  // Arbitration. burst_q != 0 means last_q was granted in the previous cycle,
  // so a nonzero burst_q is what makes the lock chain live.
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    cand       = 0;
    burst_room = (burst_q != '0) && (burst_q < BURST_W'(MAX_BURST));
    lock_hit   = burst_room && req_i[last_q] && lock_i[last_q];
    if (state_q == ST_ARB) begin
      if (lock_hit) begin
        gnt_valid = 1'b1;
        gnt_idx   = last_q;
      end else begin
        for (int unsigned i = 1; i <= REQUESTERS; i++) begin
          cand = (32'(last_q) + i) % REQUESTERS;
          if (!gnt_valid && req_i[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ID_W'(cand);
          end
        end
      end
    end
  end

  // Pointer, burst counter and output word
  always_comb begin
    last_d   = last_q;
    burst_d  = '0;
    sync_d_d = '0;
    gnt_o    = '0;
    if (gnt_valid) begin
      gnt_o    = REQUESTERS'(1) << gnt_idx;
      last_d   = gnt_idx;
      sync_d_d = {1'b1, gnt_idx, data_i[gnt_idx*DATA_SIZE +: DATA_SIZE]};
      // Same owner within the burst window keeps counting; a new owner or a
      // wrap after the limit restarts the count at 1.
      if ((gnt_idx == last_q) && burst_room) begin
        burst_d = burst_q + 1'b1;
      end else begin
        burst_d = BURST_W'(1);
      end
    end
  end

  always_ff @(posedge wrclk_i or negedge wrrst_ni) begin
    if (!wrrst_ni) begin
      state_q  <= ST_STARTUP;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      last_q   <= ID_W'(REQUESTERS - 1);
      burst_q  <= '0;
      sync_d_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      sync_d_q <= sync_d_d;
    end
  end

  assign ready_o  = ready_q;
  assign sync_d_o = sync_d_q;

endmodule

// File: tb/tb_mesochronous_sync_arbiter.sv
module tb_mesochronous_sync_arbiter;

  localparam int unsigned R     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned SC    = 4;
  localparam int unsigned MB    = 8;
  localparam int unsigned IDW   = 2;
  localparam int unsigned SW    = 1 + IDW + DW;
  localparam int          BOUND = (R - 1) * MB + 1;

  logic              rst_n;
  logic              clk;
  logic [R-1:0]      req;
  logic [R-1:0]      lock;
  logic [R*DW-1:0]   data;
  logic [R-1:0]      gnt;
  logic              ready;
  logic [SW-1:0]     sync_d;

  mesochronous_sync_arbiter #(
    .REQUESTERS    (R),
    .DATA_SIZE     (DW),
    .STARTUP_CYCLES(SC),
    .MAX_BURST     (MB)
  ) dut (
    .wrrst_ni(rst_n),
    .wrclk_i (clk),
    .req_i   (req),
    .lock_i  (lock),
    .data_i  (data),
    .gnt_o   (gnt),
    .ready_o (ready),
    .sync_d_o(sync_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model state: cycles since reset release, last owner, run length
  int m_since;
  int m_last;
  int m_run;
  int m_wait [R];
  int m_maxwait;
  logic [SW-1:0] exp_q[$];
  int obs_g;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_since = 0;
    m_last  = R - 1;
    m_run   = 0;
    for (int i = 0; i < R; i++) m_wait[i] = 0;
  endtask

  function automatic logic [R*DW-1:0] rand_data();
    logic [R*DW-1:0] v;
    for (int i = 0; i < R; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic int decode(input logic [R-1:0] g);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < R; i++) if (g[i]) begin n++; idx = i; end
    if (n > 1) return -2;
    return idx;
  endfunction

  // Called at a falling edge: drive, check the combinational grant against
  // the model, queue the word expected after the next rising edge.
  task automatic cycle(input logic [R-1:0] rq, input logic [R-1:0] lk, input logic [R*DW-1:0] dv);
    int g;
    logic exp_ready;
    logic [R-1:0] exp_gnt;
    logic [SW-1:0] w;
    req  = rq;
    lock = lk;
    data = dv;
    #1;
    exp_ready = (m_since >= SC);
    g = -1;
    if (exp_ready) begin
      if (m_run > 0 && m_run < MB && rq[m_last] && lk[m_last]) g = m_last;
      else begin
        for (int i = 1; i <= R; i++) begin
          int c;
          c = (m_last + i) % R;
          if (g < 0 && rq[c]) g = c;
        end
      end
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("gnt", gnt, exp_gnt);
    chk("ready", ready, exp_ready);
    obs_g = decode(gnt);
    w = '0;
    if (g >= 0) w = {1'b1, IDW'(g), dv[g*DW +: DW]};
    exp_q.push_back(w);
    if (exp_ready) begin
      for (int i = 0; i < R; i++) begin
        if (rq[i] && g != i) begin
          m_wait[i]++;
          if (m_wait[i] > m_maxwait) m_maxwait = m_wait[i];
        end else m_wait[i] = 0;
      end
    end
    if (g >= 0) begin
      m_run  = (g == m_last && m_run > 0 && m_run < MB) ? m_run + 1 : 1;
      m_last = g;
    end else m_run = 0;
    if (m_since < SC) m_since++;
    @(negedge clk);
  endtask

  // Asserted at a falling edge; outputs must clear without waiting for a clock.
  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_sync", sync_d, '0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one registered word per cycle
  initial begin
    logic [SW-1:0] ew;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        ew = exp_q.pop_front();
        chk("sync_d", sync_d, ew);
      end
    end
  end

  initial begin
    int seq1 [9] = '{-1, -1, -1, -1, 0, 1, 2, 3, 0};
    int seq3 [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 1};
    logic [R*DW-1:0] dv;
    logic [R-1:0] rq, lk;

    rst_n = 1'b0;
    req = '0; lock = '0; data = '0;
    m_maxwait = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("por_gnt", gnt, '0);
    chk("por_ready", ready, 1'b0);
    chk("por_sync", sync_d, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Startup window then rotating grants
    for (int i = 0; i < 9; i++) begin
      cycle(4'b1111, 4'b0000, rand_data());
      chk_int("t1_seq", obs_g, seq1[i]);
    end

    // Single request, then idle
    dv = rand_data();
    dv[2*DW +: DW] = DW'(32'hCAFE_0002);
    cycle(4'b0100, 4'b0000, dv);
    chk_int("t2_gnt", obs_g, 2);
    cycle(4'b0000, 4'b0000, rand_data());
    cycle(4'b0000, 4'b0000, rand_data());

    // Locked burst by 1 against 3, limited to MB
    cycle(4'b0001, 4'b0000, rand_data());
    for (int i = 0; i < 11; i++) begin
      cycle(4'b1010, 4'b0010, rand_data());
      chk_int("t3_seq", obs_g, seq3[i]);
    end

    // Sole locked requester across burst wraps
    cycle(4'b0000, 4'b0000, rand_data());
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0001, 4'b0001, rand_data());
      chk_int("t4_gnt", obs_g, 0);
    end

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0010, rand_data());
    reset_mid();
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 4'b0000, rand_data());
      if (i == 4) chk_int("t5_first", obs_g, 0);
    end

    // Random traffic
    m_maxwait = 0;
    for (int i = 0; i < 10000; i++) begin
      rq = R'($urandom);
      if ($urandom_range(0, 9) == 0) rq = '0;
      lk = R'($urandom | $urandom);
      cycle(rq, lk, rand_data());
    end
    chk_int("fair_wait_ok", (m_maxwait <= BOUND) ? 1 : 0, 1);

    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, rand_data());
    chk_int("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
